// File: rtl/anc_pkg.sv
// Shared constants and FSM encoding for the ANC sample path front end.
package anc_pkg;

  localparam int DATA_W         = 11;
  localparam int FRAME_BITS     = 16;
  localparam int ADC_LEAD_ZEROS = 4;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT_LO,
    SHIFT_HI,
    CS_HOLD,
    DONE
  } adc_state_e;

  // Clk_100M cycles from the first CSn-low cycle to the last: setup, two
  // half-periods per bit, hold.
  function automatic int frame_cycles(input int frame_bits, input int clk_div);
    return (2 * frame_bits + 2) * clk_div;
  endfunction

endpackage

// File: rtl/anc_spi_adc_capture_if.sv
// ADC pins plus the sample/strobe/overrun outputs of the capture block.
interface anc_spi_adc_capture_if #(
  parameter int DATA_W = anc_pkg::DATA_W
);

  logic              ADC_MISO;
  logic              ADC_SCLK;
  logic              ADC_CSn;
  logic [DATA_W-1:0] SPIData;
  logic              RamShiftEN;
  logic              Overrun;

  modport master (
    input  ADC_MISO,
    output ADC_SCLK, ADC_CSn, SPIData, RamShiftEN, Overrun
  );

  modport slave (
    output ADC_MISO,
    input  ADC_SCLK, ADC_CSn, SPIData, RamShiftEN, Overrun
  );

endinterface

// File: rtl/anc_sample_tick.sv
// Sample-rate tick generator: one-cycle tick every SAMPLE_DIV cycles while enabled.
module anc_sample_tick #(
  parameter int SAMPLE_DIV = 2000
) (
  input  logic Clk_100M,
  input  logic Reset,
  input  logic Enable,
  output logic tick
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign tick   = Enable && at_end;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and checked first.
  always_ff @(posedge Clk_100M) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else if (!Enable || at_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/anc_spi_adc_capture.sv
// SPI master for a 12-bit serial ADC: one frame per sample tick, 11-bit result
// presented with a one-cycle RamShiftEN strobe for the delay line.
module anc_spi_adc_capture
  import anc_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_BITS   = anc_pkg::FRAME_BITS,
  parameter int DATA_W       = anc_pkg::DATA_W,
  parameter int SAMPLE_DIV   = 2000,
  parameter bit TWOS_COMP    = 1'b0,
  parameter bit CHECK_TIMING = 1'b1
) (
  input  logic Clk_100M,
  input  logic Reset,
  input  logic Enable,
  anc_spi_adc_capture_if.master adc
);

  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int BIT_W    = $clog2(FRAME_BITS + 1);
  localparam int DATA_MSB = FRAME_BITS - ADC_LEAD_ZEROS - 1;

  if (CLK_DIV < 2) begin : g_clk_div_check
    $error("CLK_DIV must be at least 2");
  end
  if (CHECK_TIMING && SAMPLE_DIV <= frame_cycles(FRAME_BITS, CLK_DIV) + 2) begin : g_sample_div_check
    $error("SAMPLE_DIV too short to fit one ADC frame per sample period");
  end

  logic tick;

  anc_sample_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_sample_tick (
    .Clk_100M (Clk_100M),
    .Reset    (Reset),
    .Enable   (Enable),
    .tick     (tick)
  );

  adc_state_e            state_q, state_d;
  logic [DIV_W-1:0]      div_q;
  logic [BIT_W-1:0]      bit_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [DATA_W-1:0]     data_q, sample;
  logic                  csn_q, sclk_q, strobe_q, overrun_q;
  logic                  csn_d, sclk_d, shift_en, frame_start, div_last;
  logic                  unused_bits;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (tick)     state_d = CS_SETUP;
      CS_SETUP: if (div_last) state_d = SHIFT_LO;
      SHIFT_LO: if (div_last) state_d = SHIFT_HI;
      SHIFT_HI: if (div_last) state_d = (bit_q == BIT_W'(FRAME_BITS)) ? CS_HOLD : SHIFT_LO;
      CS_HOLD:  if (div_last) state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase

    // Pins are registered from the next state, so they change with the state.
    csn_d       = (state_d == IDLE) || (state_d == DONE);
    sclk_d      = (state_d != SHIFT_LO);
    shift_en    = (state_q == SHIFT_LO) && (state_d == SHIFT_HI);
    frame_start = (state_q == IDLE) && (state_d == CS_SETUP);
  end

  // Drop the ADC LSB; optionally flip the MSB for two's complement.
  always_comb begin
    sample = shift_q[DATA_MSB -: DATA_W];
    if (TWOS_COMP) sample[DATA_W-1] = ~sample[DATA_W-1];
  end

  always_ff @(posedge Clk_100M) begin
    if (!Reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      csn_q     <= 1'b1;
      sclk_q    <= 1'b1;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= (state_d != state_q || state_q == IDLE) ? '0 : div_q + 1'b1;
      csn_q    <= csn_d;
      sclk_q   <= sclk_d;
      strobe_q <= (state_d == DONE);

      if (frame_start) begin
        bit_q   <= '0;
        shift_q <= '0;
      end else if (shift_en) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], adc.ADC_MISO};
        bit_q   <= bit_q + 1'b1;
      end

      if (state_d == DONE) data_q <= sample;
      // A tick is only accepted in IDLE; any other state, DONE included, drops it.
      if (tick && state_q != IDLE) overrun_q <= 1'b1;
    end
  end

  // Leading zeros and the dropped LSB are shifted in but never used.
  assign unused_bits = ^{shift_q[FRAME_BITS-1 -: ADC_LEAD_ZEROS], shift_q[DATA_MSB-DATA_W:0]};

  assign adc.ADC_CSn    = csn_q;
  assign adc.ADC_SCLK   = sclk_q;
  assign adc.SPIData    = data_q;
  assign adc.RamShiftEN = strobe_q;
  assign adc.Overrun    = overrun_q;

endmodule

// File: doc/anc_spi_adc_capture.md
Name: anc_spi_adc_capture

Overview:
Upstream front end of the ANC sample path. Acts as SPI master to a 12-bit serial ADC with a 16-bit frame: 4 leading zeros, then 12 data bits, MSB first. Once per sample period it runs one conversion frame and truncates the result to 11 bits. It presents the result on SPIData with a one-cycle RamShiftEN strobe, which feeds the ANC data-memory delay line directly.

Parameters:
CLK_DIV, 4, Clk_100M cycles per SCLK half-period; legal range >= 2.
FRAME_BITS, 16, SCLK cycles per ADC frame.
DATA_W, 11, output sample width.
SAMPLE_DIV, 2000, Clk_100M cycles per sample (50 kHz); must satisfy SAMPLE_DIV > 34*CLK_DIV+2, enforced by an elaboration check.
TWOS_COMP, 0, 1 inverts the output MSB (offset binary to two's complement).

Ports:
Clk_100M  in  1  system clock, 100 MHz, all logic on rising edge
Reset  in  1  synchronous reset, active-low (asserted when 0)
Enable  in  1  allows sample ticks; 0 holds the tick counter at 0
ADC_MISO  in  1  serial data from ADC
ADC_SCLK  out  1  SPI clock, idle high
ADC_CSn  out  1  ADC chip select, active low
SPIData  out  DATA_W  last captured sample
RamShiftEN  out  1  one-cycle strobe: SPIData is new, shift the delay line
Overrun  out  1  sticky: a tick arrived while a frame was in progress

Behaviour:
- Reset (Reset=0 at an edge), effective next cycle:
  - ADC_CSn=1, ADC_SCLK=1, SPIData=0, RamShiftEN=0, Overrun=0.
  - FSM=IDLE, tick counter=0, shift register=0, bit counter=0.
- Reset mid-frame: aborts immediately; no RamShiftEN; SPIData keeps 0.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 while Enable=1 and wraps.
  - Tick = cycle in which count==SAMPLE_DIV-1.
  - Enable=0 holds the count at 0 and generates no ticks; a frame already in progress completes normally.
- FSM states: IDLE, CS_SETUP, SHIFT_LO, SHIFT_HI, CS_HOLD, DONE.
  - IDLE: on tick -> CS_SETUP; ADC_CSn=0 from the next cycle.
  - CS_SETUP: CLK_DIV cycles, SCLK=1 -> SHIFT_LO.
  - SHIFT_LO: CLK_DIV cycles, SCLK=0 -> SHIFT_HI.
  - SHIFT_HI: CLK_DIV cycles, SCLK=1.
    - On the edge that drives SCLK 0->1 (the SHIFT_LO->SHIFT_HI transition), ADC_MISO is shifted into the LSB of a 16-bit shift register and the bit counter increments.
    - After the 16th bit -> CS_HOLD; otherwise -> SHIFT_LO.
  - CS_HOLD: CLK_DIV cycles, SCLK=1, CSn=0 -> DONE.
  - DONE: 1 cycle -> IDLE.
    - ADC_CSn=1.
    - SPIData <= shift[11:1] (bit 0 dropped; shift[15:12] ignored), MSB inverted if TWOS_COMP=1.
    - RamShiftEN=1, this cycle only.
- Latency: the RamShiftEN cycle is exactly 1+34*CLK_DIV cycles after the tick cycle (137 at CLK_DIV=4). ADC_CSn is low for 34*CLK_DIV cycles.
- SPIData holds its value between strobes and changes only in the RamShiftEN cycle.
- Overrun:
  - Tick while FSM != IDLE: tick dropped, Overrun set.
  - Overrun is cleared only by reset.
  - A tick in the DONE cycle also counts as overrun.
- SCLK is a registered output with no glitches; ADC_CSn and ADC_SCLK are both registered.

Decomposition:
- Shared package anc_pkg: DATA_W=11, FRAME_BITS=16, ADC_LEAD_ZEROS=4, FSM state encoding constants.
- One sub-module anc_sample_tick: parameter SAMPLE_DIV, inputs Clk_100M/Reset/Enable, output tick. The ANC filter control can reuse it.
- Everything else stays in this module.

Test Plan:
- Reset held 0 for 5 cycles mid-frame -> next cycle CSn=1, SCLK=1, SPIData=0, Overrun=0; no RamShiftEN pulse follows.
- MISO drives 0x0ABC MSB-first, aligned to SCLK, TWOS_COMP=0 -> one RamShiftEN pulse at tick+137; SPIData=0x55E; CSn low for exactly 136 cycles; 16 SCLK rising edges.
- Same frame with TWOS_COMP=1 -> SPIData=0x15E; 0x0FFF -> 0x7FF (0x3FF with TWOS_COMP=1); 0x0000 -> 0x000.
- Enable=1 for 3 periods with SAMPLE_DIV=2000 -> RamShiftEN pulses exactly 2000 cycles apart, each one cycle wide; SPIData is stable between pulses.
- Enable dropped mid-frame -> that frame completes with a pulse at tick+137; no further CSn activity while Enable=0.
- SAMPLE_DIV forced to 100 (check bypassed), CLK_DIV=4 -> Overrun=1 after the second tick; the in-flight frame still completes and pulses RamShiftEN.
